// File: rtl/sipo_deser.sv
// sipo_deser: serial-in / parallel-out deserializer with a one-word holding stage.
//
// Serial bits arrive MSB-first on d, qualified by en. Every WIDTH enabled bits
// form a word that is handed to a holding register (q_par/valid). The holder
// is released by ready. A word that completes while the holder is still
// occupied and not being released is dropped, and the sticky ovf flag is set.
//
// Ports
//   clk    in   1      single clock, rising edge
//   rst_n  in   1      synchronous active-low reset
//   d      in   1      serial data bit
//   en     in   1      shift enable, d is sampled only when en=1
//   ready  in   1      downstream accepts the held word
//   q_par  out  WIDTH  last accepted parallel word
//   valid  out  1      q_par holds an unconsumed word
//   ovf    out  1      sticky overflow, cleared only by reset
//   cnt    out  CW     bits collected in the current partial word
//
// Holding FSM
//   state | meaning
//   EMPTY | no word held, valid=0, ready ignored
//   FULL  | word held in q_par, valid=1, waiting for ready

module sipo_deser #(
  parameter int WIDTH = 8,
  localparam int CW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d,
  input  logic             en,
  input  logic             ready,
  output logic [WIDTH-1:0] q_par,
  output logic             valid,
  output logic             ovf,
  output logic [CW-1:0]    cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_q_par;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;

  logic [WIDTH-1:0] w_sr_nxt;
  logic             w_complete;
  logic             w_load;
  logic             w_set_ovf;

  // The completed word includes the bit being sampled on this edge, so the
  // holder is loaded from the next shift-register value, not the current one.
  assign w_sr_nxt   = {r_sr[WIDTH-2:0], d};
  assign w_complete = en && (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_set_ovf   = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_complete) begin
          w_load      = 1'b1;
          w_state_nxt = FULL;
        end
      end
      FULL: begin
        if (w_complete) begin
          // Release and refill on the same edge keeps the holder full.
          if (ready) w_load    = 1'b1;
          else       w_set_ovf = 1'b1;
        end else if (ready) begin
          w_state_nxt = EMPTY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_q_par <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (en) begin
        r_sr  <= w_sr_nxt;
        r_cnt <= w_complete ? '0 : r_cnt + 1'b1;
      end
      if (w_load)    r_q_par <= w_sr_nxt;
      if (w_set_ovf) r_ovf   <= 1'b1;
    end
  end

  assign q_par = r_q_par;
  assign valid = (r_state == FULL);
  assign ovf   = r_ovf;
  assign cnt   = r_cnt;

endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the deserialized word width; legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port d, input, 1 bit: serial data bit, normally the q output of the upstream D flip-flop stage.
REQ-005 SHALL have port en, input, 1 bit: shift enable; d is sampled only on edges where en=1.
REQ-006 SHALL have port ready, input, 1 bit: downstream accepts the held word.
REQ-007 SHALL have port q_par, output, WIDTH bits: last completed parallel word, registered.
REQ-008 SHALL have port valid, output, 1 bit: q_par holds an unconsumed word, registered.
REQ-009 SHALL have port ovf, output, 1 bit: sticky overflow flag, registered.
REQ-010 SHALL have port cnt, output, $clog2(WIDTH) bits: bits collected in the current partial word, registered.

Function
REQ-011 SHALL shift MSB-first: on an edge with en=1, the shift register becomes {sr[WIDTH-2:0], d}, and cnt increments.
REQ-012 SHALL hold sr and cnt unchanged on edges with en=0; gaps of any length are legal mid-word.
REQ-013 SHALL complete a word on an edge with en=1 and cnt=WIDTH-1; cnt wraps to 0 on that same edge.
REQ-014 SHALL use a two-state holding FSM: EMPTY (valid=0) and FULL (valid=1).
REQ-015 In EMPTY, on word completion, SHALL load q_par with {sr[WIDTH-2:0], d} and go to FULL; valid is seen high immediately after the completing edge (zero added latency).
REQ-016 In FULL, on an edge with ready=1 and no completion, SHALL go to EMPTY; q_par holds its value.
REQ-017 In FULL, on an edge with ready=1 and a completion, SHALL load the new word and stay FULL; ovf is not set.
REQ-018 In FULL, on an edge with ready=0 and a completion, SHALL drop the new word, leave q_par unchanged, stay FULL, and set ovf.
REQ-019 SHALL keep ovf at 1 once set until reset; ovf has no other clear path.
REQ-020 SHALL ignore ready while in EMPTY.
REQ-021 SHALL continue shifting normally during FULL; only the completion transfer is affected by ready.

Reset
REQ-022 While rst_n=0 at an edge, SHALL force sr=0, cnt=0, q_par=0, valid=0, ovf=0, and state EMPTY, regardless of en, d, or ready.
REQ-023 A reset mid-word SHALL discard the partial word; the first en=1 edge after release is bit WIDTH-1 (MSB) of a new word.
REQ-024 Outputs SHALL be defined (no X) from the first edge with rst_n=0.

Verification (WIDTH=8)
REQ-025 Reset: rst_n=0 for 2 edges, with en=1 and d=1 -> q_par=8'h00, valid=0, ovf=0, cnt=0.
REQ-026 Single word: en=1, ready=0, bits of 8'hA5 MSB-first over 8 edges -> after edge 8, valid=1, q_par=8'hA5, cnt=0, ovf=0.
REQ-027 Enable gap: bits 1,0,1,1, then en=0 for 3 edges, then bits 0,0,1,0 -> cnt stays 4 during the gap; final q_par=8'hB2, valid=1.
REQ-028 Back-to-back with ready=1: 8'h3C then 8'hC3 over 16 continuous edges -> valid high for one edge after edge 8 with q_par=8'h3C; after edge 16, q_par=8'hC3; ovf=0.
REQ-029 Overflow: 8'h55 then 8'hFF with ready=0 -> q_par stays 8'h55, ovf=1 after edge 16; then ready=1 for one edge -> valid=0, ovf still 1.
REQ-030 Reset mid-word: 5 bits shifted, then rst_n=0 for one edge, then 8'h81 shifted -> cnt=0 after reset; after 8 further edges q_par=8'h81, valid=1.
